// File: rtl/seq_cmp_scheduler.sv
// ---------------------------------------------------------------------------
// seq_cmp_scheduler
//
// Two-port round-robin front end for one shared bit-serial comparator.
// A request is granted, its operands are captured, the comparator is loaded
// for one cycle, run for WIDTH bit-cycles, and the L/E/G flags are returned
// to the granted requester together with a one-cycle done pulse.
//
// Optional build macro: SEQ_CMP_SCHED_STATS_EN adds per-requester 16-bit
// saturating completion counters (cnt0, cnt1).
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req0/req1             level requests
//   a0/b0/op0, a1/b1/op1  operand pair and OP of each requester
//   gnt0/gnt1             one-cycle grant pulse (operands captured)
//   done0/done1           one-cycle result-valid pulse
//   res_L/res_E/res_G     registered result flags, held until next done
//   busy                  high whenever the scheduler is not idle
//   cmp_inp1/cmp_inp2     registered operands to the comparator
//   cmp_op                registered OP to the comparator
//   cmp_reset             comparator reset/load strobe (combinational)
//   cmp_L/cmp_E/cmp_G     comparator result flags
//   cnt0/cnt1             completion counters (stats build only)
//
// Handshake (valid/ready): req is the valid, gnt is the single-cycle ready.
// A requester holds req until it sees gnt and drops it the next cycle;
// operands may change once gnt has been seen. A req still high when the
// scheduler returns to idle is a new request.
// ---------------------------------------------------------------------------
module seq_cmp_scheduler #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic             op0,
   input  logic             op1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic             res_L,
   output logic             res_E,
   output logic             res_G,
   output logic             busy,
   output logic [WIDTH-1:0] cmp_inp1,
   output logic [WIDTH-1:0] cmp_inp2,
   output logic             cmp_op,
   output logic             cmp_reset,
`ifdef SEQ_CMP_SCHED_STATS_EN
   output logic [15:0]      cnt0,
   output logic [15:0]      cnt1,
`endif
   input  logic             cmp_L,
   input  logic             cmp_E,
   input  logic             cmp_G
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state;
   state_t           next_state;
   logic             sel;        // requester currently being served
   logic             last;       // requester served most recently
   logic [CNT_W-1:0] counter;
   logic             pick_valid;
   logic             pick_sel;

   // Arbitration: a lone request wins outright; on contention the requester
   // that was not served last time wins.
   always_comb begin
      pick_valid = req0 | req1;
      pick_sel   = 1'b0;
      if (req0 && req1) pick_sel = ~last;
      else              pick_sel = req1;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: if (pick_valid) next_state = S_LOAD;
         S_LOAD: next_state = S_RUN;
         S_RUN:  if (counter == CNT_W'(WIDTH - 1)) next_state = S_DONE;
         S_DONE: next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Idle and load both keep the comparator in reset, so it is never
   // clocking stale data while unused; reset itself forces it too.
   assign cmp_reset = reset | (state == S_IDLE) | (state == S_LOAD);
   assign busy      = (state != S_IDLE);

   // Datapath and pulse outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         res_L    <= 1'b0;
         res_E    <= 1'b0;
         res_G    <= 1'b0;
         cmp_inp1 <= '0;
         cmp_inp2 <= '0;
         cmp_op   <= 1'b0;
         counter  <= '0;
         sel      <= 1'b0;
         last     <= 1'b1;  // requester 0 wins the first contention
      end else begin
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_valid) begin
                  sel      <= pick_sel;
                  gnt0     <= ~pick_sel;
                  gnt1     <= pick_sel;
                  cmp_inp1 <= pick_sel ? a1  : a0;
                  cmp_inp2 <= pick_sel ? b1  : b0;
                  cmp_op   <= pick_sel ? op1 : op0;
               end
            end
            S_LOAD: counter <= '0;
            S_RUN:  counter <= counter + CNT_W'(1);
            S_DONE: begin
               res_L <= cmp_L;
               res_E <= cmp_E;
               res_G <= cmp_G;
               done0 <= ~sel;
               done1 <= sel;
               last  <= sel;
            end
            default: ;
         endcase
      end
   end

`ifdef SEQ_CMP_SCHED_STATS_EN
   // Completion counters, saturating so they never roll back to small values
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt0 <= 16'd0;
         cnt1 <= 16'd0;
      end else if (state == S_DONE) begin
         if (!sel && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
         if (sel  && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_seq_cmp_scheduler.sv
// ---------------------------------------------------------------------------
// tb_seq_cmp_scheduler
//
// Bench for seq_cmp_scheduler. A behavioural stand-in for the bit-serial
// comparator captures operands while cmp_reset is high and only presents
// valid flags after WIDTH run cycles. Expected results come from plain
// arithmetic compares queued at grant time and popped at done.
// ---------------------------------------------------------------------------
module tb_seq_cmp_scheduler;

   localparam int WIDTH = 32;
   localparam int CNT_W = 6;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic             req0, req1, op0, op1;
   logic [WIDTH-1:0] a0, b0, a1, b1;
   logic             gnt0, gnt1, done0, done1;
   logic             res_L, res_E, res_G, busy;
   logic [WIDTH-1:0] cmp_inp1, cmp_inp2;
   logic             cmp_op, cmp_reset;
   logic             cmp_L, cmp_E, cmp_G;
`ifdef SEQ_CMP_SCHED_STATS_EN
   logic [15:0]      cnt0, cnt1;
`endif

   seq_cmp_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(rst),
      .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .op0(op0), .op1(op1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .res_L(res_L), .res_E(res_E), .res_G(res_G), .busy(busy),
      .cmp_inp1(cmp_inp1), .cmp_inp2(cmp_inp2),
      .cmp_op(cmp_op), .cmp_reset(cmp_reset),
`ifdef SEQ_CMP_SCHED_STATS_EN
      .cnt0(cnt0), .cnt1(cnt1),
`endif
      .cmp_L(cmp_L), .cmp_E(cmp_E), .cmp_G(cmp_G)
   );

   // ---------------- reference compare ----------------
   // op=0 unsigned, op=1 signed; result packed as {L,E,G}
   function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic op);
      logic lt, eq;
      eq = (a == b);
      if (op) lt = ($signed(a) < $signed(b));
      else    lt = (a < b);
      return {lt, eq, !lt && !eq};
   endfunction

   // ---------------- comparator stand-in ----------------
   logic [WIDTH-1:0] m_a = '0, m_b = '0;
   logic             m_op = 1'b0;
   int               m_cnt = 0;
   logic [2:0]       m_f;

   always @(posedge clk) begin
      if (cmp_reset) begin
         m_a   <= cmp_inp1;
         m_b   <= cmp_inp2;
         m_op  <= cmp_op;
         m_cnt <= 0;
      end else if (m_cnt < WIDTH + 4) begin
         m_cnt <= m_cnt + 1;
      end
   end

   always_comb begin
      m_f   = ref_cmp(m_a, m_b, m_op);
      cmp_L = (m_cnt >= WIDTH) && m_f[2];
      cmp_E = (m_cnt >= WIDTH) && m_f[1];
      cmp_G = (m_cnt >= WIDTH) && m_f[0];
   end

   // ---------------- scoreboard state ----------------
   int         n_checks = 0;
   int         n_fail   = 0;
   int         ref_last = 1;
   int         exp_cnt0 = 0;
   int         exp_cnt1 = 0;
   int         last_gnt = 0;
   logic [3:0] exp_q[$];   // {sel, L, E, G}
   int         order[4];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic r0, input logic r1);
      if (r0 && r1) return 1 - ref_last;
      return r1 ? 1 : 0;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values();
      chk("rst_gnt0",  64'(gnt0),  64'd0);
      chk("rst_gnt1",  64'(gnt1),  64'd0);
      chk("rst_done0", 64'(done0), 64'd0);
      chk("rst_done1", 64'(done1), 64'd0);
      chk("rst_res",   64'({res_L, res_E, res_G}), 64'd0);
      chk("rst_busy",  64'(busy),  64'd0);
      chk("rst_inp1",  64'(cmp_inp1), 64'd0);
      chk("rst_inp2",  64'(cmp_inp2), 64'd0);
      chk("rst_op",    64'(cmp_op), 64'd0);
      chk("rst_cmp_reset", 64'(cmp_reset), 64'd1);
`ifdef SEQ_CMP_SCHED_STATS_EN
      chk("rst_cnt0", 64'(cnt0), 64'd0);
      chk("rst_cnt1", 64'(cnt1), 64'd0);
`endif
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      tick();
      check_reset_values();
      rst      = 1'b0;
      ref_last = 1;
      exp_cnt0 = 0;
      exp_cnt1 = 0;
      exp_q.delete();
      tick();
   endtask

   // Serve one transaction. Called in an idle cycle with the request lines
   // already set. raise_other_at raises the other requester at that run
   // cycle; rehold re-raises the granted requester so it contends again.
   task automatic serve(input int raise_other_at, input bit rehold);
      int               es, lat;
      logic [WIDTH-1:0] ea, eb;
      logic             eo;
      logic [3:0]       e;
      bit               got;
      es = pick(req0, req1);
      ea = es ? a1 : a0;
      eb = es ? b1 : b0;
      eo = es ? op1 : op0;
      exp_q.push_back({es[0], ref_cmp(ea, eb, eo)});

      got = 0;
      lat = 0;
      for (int i = 1; i <= 4 && !got; i++) begin
         tick();
         lat = i;
         got = gnt0 | gnt1;
      end
      chk("gnt_latency", 64'(lat), 64'd1);
      if (!got) begin
         void'(exp_q.pop_front());
         return;
      end
      last_gnt = gnt1 ? 1 : 0;
      chk("gnt0", 64'(gnt0), 64'(es == 0));
      chk("gnt1", 64'(gnt1), 64'(es == 1));
      chk("load_cmp_reset", 64'(cmp_reset), 64'd1);
      chk("load_busy", 64'(busy), 64'd1);
      chk("cmp_inp1", 64'(cmp_inp1), 64'(ea));
      chk("cmp_inp2", 64'(cmp_inp2), 64'(eb));
      chk("cmp_op", 64'(cmp_op), 64'(eo));

      // Granted requester drops req and scrambles its operands
      if (es == 0) begin
         req0 = 1'b0; a0 = $urandom; b0 = $urandom; op0 = 1'($urandom_range(0, 1));
      end else begin
         req1 = 1'b0; a1 = $urandom; b1 = $urandom; op1 = 1'($urandom_range(0, 1));
      end

      got = 0;
      lat = 0;
      for (int i = 1; i <= WIDTH + 6 && !got; i++) begin
         tick();
         lat = i;
         if (i == raise_other_at) begin
            if (es == 0) req1 = 1'b1;
            else         req0 = 1'b1;
         end
         if (rehold && i == 3) begin
            if (es == 0) req0 = 1'b1;
            else         req1 = 1'b1;
         end
         got = done0 | done1;
         if (!got) begin
            chk("run_cmp_reset", 64'(cmp_reset), 64'd0);
            chk("run_busy", 64'(busy), 64'd1);
            chk("run_no_gnt", 64'(gnt0 | gnt1), 64'd0);
         end
      end
      chk("done_latency", 64'(lat), 64'(WIDTH + 2));
      e = exp_q.pop_front();
      chk("done0", 64'(done0), 64'(!e[3]));
      chk("done1", 64'(done1), 64'(e[3]));
      chk("res_flags", 64'({res_L, res_E, res_G}), 64'(e[2:0]));
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_cmp_reset", 64'(cmp_reset), 64'd1);

      ref_last = es;
      if (es == 0 && exp_cnt0 < 16'hFFFF) exp_cnt0++;
      if (es == 1 && exp_cnt1 < 16'hFFFF) exp_cnt1++;
`ifdef SEQ_CMP_SCHED_STATS_EN
      chk("cnt0", 64'(cnt0), 64'(exp_cnt0));
      chk("cnt1", 64'(cnt1), 64'(exp_cnt1));
`endif
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      req0 = 0; req1 = 0; op0 = 0; op1 = 0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      rst = 1'b1;
      #2;
      check_reset_values();
      do_reset();

      // Single request, less-than
      a0 = 32'd5; b0 = 32'd9; op0 = 1'b0; req0 = 1'b1;
      serve(0, 0);
      chk("t1_L", 64'(res_L), 64'd1);
      chk("t1_E", 64'(res_E), 64'd0);
      chk("t1_G", 64'(res_G), 64'd0);

      // Equal
      a1 = 32'hDEADBEEF; b1 = 32'hDEADBEEF; op1 = 1'b0; req1 = 1'b1;
      serve(0, 0);
      chk("t2_E", 64'(res_E), 64'd1);

      // Greater (unsigned)
      a1 = 32'h80000000; b1 = 32'h7FFFFFFF; op1 = 1'b0; req1 = 1'b1;
      serve(0, 0);
      chk("t3_G", 64'(res_G), 64'd1);

      // Reset in the middle of RUN
      a0 = $urandom; b0 = $urandom; op0 = 1'b0; req0 = 1'b1;
      tick();
      chk("mid_gnt0", 64'(gnt0), 64'd1);
      req0 = 1'b0;
      for (int i = 0; i < 11; i++) tick();   // LOAD then RUN cycles 0..9
      #1 rst = 1'b1;
      #1 check_reset_values();
      tick();
      chk("mid_no_done", 64'(done0 | done1), 64'd0);
      check_reset_values();
      rst = 1'b0;
      ref_last = 1; exp_cnt0 = 0; exp_cnt1 = 0;
      tick();
      a0 = $urandom; b0 = $urandom; op0 = 1'b1; req0 = 1'b1;
      serve(0, 0);

      // Contention fairness from reset: 0,1,0,1
      do_reset();
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      req0 = 1'b1; req1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         serve(0, 1);
         order[k] = last_gnt;
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("fair_0", 64'(order[0]), 64'd0);
      chk("fair_1", 64'(order[1]), 64'd1);
      chk("fair_2", 64'(order[2]), 64'd0);
      chk("fair_3", 64'(order[3]), 64'd1);
      tick();

      // Late request raised mid-RUN of requester 0
      a0 = $urandom; b0 = $urandom; req0 = 1'b1;
      serve(10, 0);
      chk("late_req_held", 64'(req1), 64'd1);
      serve(0, 0);
      chk("late_served_1", 64'(last_gnt), 64'd1);

      // Completion counting: three for requester 0, two for requester 1
      do_reset();
      for (int k = 0; k < 5; k++) begin
         if (k < 3) begin a0 = $urandom; b0 = $urandom; req0 = 1'b1; end
         else       begin a1 = $urandom; b1 = $urandom; req1 = 1'b1; end
         serve(0, 0);
      end
`ifdef SEQ_CMP_SCHED_STATS_EN
      chk("stats_cnt0", 64'(cnt0), 64'd3);
      chk("stats_cnt1", 64'(cnt1), 64'd2);
`endif
      do_reset();

      // Random traffic
      for (int k = 0; k < 20; k++) begin
         req0 = 1'($urandom_range(0, 1));
         req1 = 1'($urandom_range(0, 1));
         if (!req0 && !req1) req0 = 1'b1;
         a0 = $urandom; a1 = $urandom;
         b0 = ($urandom_range(0, 3) == 0) ? a0 : 32'($urandom);
         b1 = ($urandom_range(0, 3) == 0) ? a1 : 32'($urandom);
         op0 = 1'($urandom_range(0, 1));
         op1 = 1'($urandom_range(0, 1));
         serve(0, 0);
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Grant and done pulses are mutually exclusive at all times
   always @(negedge clk) begin
      if (!rst) begin
         chk("gnt_exclusive", 64'(gnt0 & gnt1), 64'd0);
         chk("done_exclusive", 64'(done0 & done1), 64'd0);
      end
   end

endmodule

// File: doc/seq_cmp_scheduler.md
Name: seq_cmp_scheduler

Overview:
- Sequencer and two-port round-robin arbiter for the bit-serial 32-bit comparator (`seq_comparator`).
- Two requesters each present an operand pair plus OP. The scheduler grants one requester and captures its operands. It then loads the comparator, lets it run WIDTH bit-cycles, captures L/E/G and returns the result with a done pulse.
- Sits between client logic and a single `seq_comparator` instance so that instance can be shared.

Parameters:
- WIDTH, 32, operand width and number of serial compare cycles; must match the comparator's shift registers.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0, req1  input  1  level request from requester 0 / 1.
- a0, b0, a1, b1  input  WIDTH  operand pair of requester 0 / 1.
- op0, op1  input  1  OP value of requester 0 / 1.
- gnt0, gnt1  output  1  one-cycle pulse: request accepted, operands captured.
- done0, done1  output  1  one-cycle pulse: result valid for that requester.
- res_L, res_E, res_G  output  1  registered result flags, held until the next DONE.
- busy  output  1  high in every state except IDLE.
- cmp_inp1, cmp_inp2  output  WIDTH  registered operands to the comparator.
- cmp_op  output  1  registered OP to the comparator.
- cmp_reset  output  1  comparator reset/load strobe.
- cmp_L, cmp_E, cmp_G  input  1  comparator result flags.

Behaviour:
- Reset values while reset is high (asynchronous):
  - state=IDLE.
  - gnt*=0, done*=0, res_L=res_E=res_G=0, busy=0.
  - cmp_inp1=cmp_inp2=0, cmp_op=0, counter=0.
  - last=1, so requester 0 wins first.
- cmp_reset = reset OR state==IDLE OR state==LOAD. It is combinational, so the comparator is held reset whenever it is unused.
- IDLE:
  - No request pending: stay in IDLE.
  - Exactly one request: select it.
  - Both requests: select the requester != last.
  - On selection, latch its a/b/op into cmp_inp1/cmp_inp2/cmp_op, set sel, pulse gnt_sel for 1 cycle, go to LOAD.
- LOAD: one cycle with cmp_reset high so the comparator shift registers load cmp_inp1/2. Clear the counter and go to RUN.
- RUN:
  - cmp_reset is low and the counter increments each cycle.
  - When counter==WIDTH-1, go to DONE; exactly WIDTH compare cycles elapse.
- DONE:
  - Sample cmp_L/E/G into res_L/E/G and pulse done_sel for 1 cycle.
  - Set last=sel and return to IDLE.
- Latency: gnt at edge 0, LOAD cycle 1, RUN cycles 2..WIDTH+1, done at cycle WIDTH+2. Back-to-back throughput is one result per WIDTH+3 cycles.
- Handshake:
  - The requester holds req until it sees gnt, then must drop req in the following cycle.
  - Operands may change after gnt.
  - A req still high when the scheduler is back in IDLE is treated as a new request.
- Requests arriving during LOAD/RUN/DONE are ignored until IDLE. No queueing or loss is required beyond the requester holding req.
- gnt0&gnt1 and done0&done1 are never simultaneously high.
- Reset mid-operation:
  - The in-flight comparison is aborted with no done pulse.
  - res_* clear to 0 and the comparator is held in reset.
- Counter wrap: never wraps, because RUN exits at WIDTH-1.

Optional Feature:
- Macro SEQ_CMP_SCHED_STATS_EN.
- When defined, add output ports cnt0 and cnt1, each 16 bits.
  - Each counts DONE events for its requester, saturating at 16'hFFFF.
  - Both clear on reset.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-RUN: reset asserted at RUN cycle 10 -> no done pulse, all outputs at reset values, cmp_reset=1; a following req0 is served normally.
- Single request: req0 with a0=5, b0=9, op0=0 -> gnt0 one cycle later, cmp_reset high 1 cycle, done0 exactly WIDTH+2=34 cycles after gnt0, res_L=1, res_E=0, res_G=0.
- Equal and greater: req1 with a1=b1=32'hDEADBEEF -> done1 with res_E=1. Then a1=32'h80000000, b1=32'h7FFFFFFF -> res_G=1.
- Contention fairness: req0 and req1 high in the same IDLE cycle after reset -> gnt0 first, then gnt1. Keeping both high for 4 transactions gives an alternating 0,1,0,1 sequence.
- Late request: req1 raised mid-RUN of requester 0 -> ignored until IDLE, then gnt1 in the first IDLE cycle after done0; busy stays low only in that single cycle.
- Stats, with SEQ_CMP_SCHED_STATS_EN: 3 transactions for requester 0 and 2 for requester 1 -> cnt0=3, cnt1=2; after reset both read 0.
